// File: rtl/module_alu_input_sequencer_pkg.sv
// Shared types for the ALU input sequencer: operand width, opcode width and
// the load-sequence state encoding.
package pkg_bits;

    localparam int OPC_W = 4;

    typedef logic [7:0] bits_t;

    typedef enum logic [1:0] {
        S_LOAD_A  = 2'd0,
        S_LOAD_B  = 2'd1,
        S_LOAD_OP = 2'd2,
        S_READY   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/module_alu_input_sequencer_edge_detect.sv
// Rising-edge detector for the load button. Define ALU_SEQ_SYNC_EN to place a
// two-flop synchronizer in front of it for pad-driven inputs.
module module_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

`ifdef ALU_SEQ_SYNC_EN
    localparam logic [1:0] ARM_CNT = 2'd3;
    logic [1:0] r_sync;
    logic       w_sig_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_sync <= 2'b00;
        else       r_sync <= {r_sync[0], sig_i};
    end

    assign w_sig_s = r_sync[1];
`else
    localparam logic [1:0] ARM_CNT = 2'd1;
    logic w_sig_s;

    assign w_sig_s = sig_i;
`endif

    logic       r_load_q;
    logic [1:0] r_arm_cnt;

    // Edges are masked until the pipeline has re-sampled the input after
    // reset, so a button still held through reset does not count as a press.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_load_q  <= 1'b0;
            r_arm_cnt <= 2'd0;
        end else begin
            r_load_q <= w_sig_s;
            if (r_arm_cnt != ARM_CNT) r_arm_cnt <= r_arm_cnt + 2'd1;
        end
    end

    assign rise_o = w_sig_s & ~r_load_q & (r_arm_cnt == ARM_CNT);

endmodule

// File: rtl/module_alu_input_sequencer.sv
// Loads ALU operands A, B and opcode from a shared switch bus, one per button
// press, and captures the ALU result once the set is complete.
module module_alu_input_sequencer
    import pkg_bits::*;
#(
    parameter logic [OPC_W-1:0] RESET_CTRL = 4'h0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  bits_t            data_i,
    input  logic             load_i,
    input  bits_t            aluresult_i,
    input  logic             aluflags_i,
    output bits_t            alua_o,
    output bits_t            alub_o,
    output logic [OPC_W-1:0] alucontrol_o,
    output logic             aluflagin_o,
    output logic             valid_o,
    output bits_t            result_o,
    output logic             flag_o,
    output logic             result_valid_o,
    output logic [1:0]       state_o
);

    seq_state_t       r_state, w_state_nxt;
    logic             w_ev, w_ld_a, w_ld_b, w_ld_op;
    bits_t            r_alua, r_alub, r_result;
    logic [OPC_W-1:0] r_ctrl;
    logic             r_flagin, r_flag, r_result_valid;

    module_edge_detect u_edge_detect (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sig_i  (load_i),
        .rise_o (w_ev)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_LOAD_A;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_a      = 1'b0;
        w_ld_b      = 1'b0;
        w_ld_op     = 1'b0;
        if (w_ev) begin
            case (r_state)
                S_LOAD_A:  begin w_ld_a  = 1'b1; w_state_nxt = S_LOAD_B;  end
                S_LOAD_B:  begin w_ld_b  = 1'b1; w_state_nxt = S_LOAD_OP; end
                S_LOAD_OP: begin w_ld_op = 1'b1; w_state_nxt = S_READY;   end
                // A press in READY starts the next set directly with operand A.
                S_READY:   begin w_ld_a  = 1'b1; w_state_nxt = S_LOAD_B;  end
                default:   w_state_nxt = S_LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_alua   <= '0;
            r_alub   <= '0;
            r_ctrl   <= RESET_CTRL;
            r_flagin <= 1'b0;
        end else begin
            if (w_ld_a) r_alua <= data_i;
            if (w_ld_b) r_alub <= data_i;
            if (w_ld_op) begin
                r_ctrl   <= data_i[OPC_W-1:0];
                r_flagin <= data_i[OPC_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result       <= '0;
            r_flag         <= 1'b0;
            r_result_valid <= 1'b0;
        end else if (w_ev && r_state == S_READY) begin
            r_result_valid <= 1'b0;
        end else if (r_state == S_READY && !r_result_valid) begin
            r_result       <= aluresult_i;
            r_flag         <= aluflags_i;
            r_result_valid <= 1'b1;
        end
    end

    assign alua_o         = r_alua;
    assign alub_o         = r_alub;
    assign alucontrol_o   = r_ctrl;
    assign aluflagin_o    = r_flagin;
    assign valid_o        = (r_state == S_READY);
    assign result_o       = r_result;
    assign flag_o         = r_flag;
    assign result_valid_o = r_result_valid;
    assign state_o        = r_state;

endmodule

// File: tb/tb_module_alu_input_sequencer.sv
// Self-checking bench for module_alu_input_sequencer; a small ALU model drives
// the result inputs and expected captures flow through a scoreboard queue.
module tb_module_alu_input_sequencer;
    import pkg_bits::*;

`ifdef ALU_SEQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam logic [3:0] RESET_CTRL = 4'h0;

    typedef struct {
        logic [7:0] res;
        logic       flag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_i = 8'h00;
    logic       load_i = 1'b0;
    logic [7:0] aluresult_i;
    logic       aluflags_i;
    logic [7:0] alua_o, alub_o, result_o;
    logic [3:0] alucontrol_o;
    logic       aluflagin_o, valid_o, flag_o, result_valid_o;
    logic [1:0] state_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    module_alu_input_sequencer #(.RESET_CTRL(RESET_CTRL)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_i         (data_i),
        .load_i         (load_i),
        .aluresult_i    (aluresult_i),
        .aluflags_i     (aluflags_i),
        .alua_o         (alua_o),
        .alub_o         (alub_o),
        .alucontrol_o   (alucontrol_o),
        .aluflagin_o    (aluflagin_o),
        .valid_o        (valid_o),
        .result_o       (result_o),
        .flag_o         (flag_o),
        .result_valid_o (result_valid_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    // Reference ALU: AND, OR, SUB, ADD (flag = carry), otherwise XOR; flag = zero.
    function automatic exp_t alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        exp_t    e;
        logic [8:0] s;
        s = 9'd0;
        case (op)
            4'd0:    e.res = a & b;
            4'd1:    e.res = a | b;
            4'd2:    e.res = a - b;
            4'd3:    begin s = {1'b0, a} + {1'b0, b}; e.res = s[7:0]; end
            default: e.res = a ^ b;
        endcase
        e.flag = (op == 4'd3) ? s[8] : (e.res == 8'h00);
        return e;
    endfunction

    always_comb begin
        exp_t e;
        e           = alu_ref(alua_o, alub_o, alucontrol_o);
        aluresult_i = e.res;
        aluflags_i  = e.flag;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on each new capture; also checks the one-cycle gap after valid.
    int   cyc = 0, valid_cyc = 0;
    logic valid_prev = 1'b0, rv_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (valid_o && !valid_prev) valid_cyc = cyc;
        if (result_valid_o && !rv_prev) begin
            exp_t e;
            check("rv_after_valid", cyc - valid_cyc, 1);
            check("sb_avail", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("result", result_o, e.res);
                check("flag", flag_o, e.flag);
            end
        end
        valid_prev = valid_o;
        rv_prev    = result_valid_o;
    end

    // Press with load held for 'hold' edges; lat = edges until state changes (0 = never).
    task automatic press(input logic [7:0] d, input int hold, output int lat);
        logic [1:0] s0;
        @(negedge clk);
        data_i = d;
        load_i = 1'b1;
        s0     = state_o;
        lat    = 0;
        for (int i = 1; i <= hold + LAT + 3; i++) begin
            @(posedge clk);
            #1;
            if (i == hold) load_i = 1'b0;
            if (lat == 0 && state_o != s0) lat = i;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_alua", alua_o, 8'h00);
        check("rst_alub", alub_o, 8'h00);
        check("rst_ctrl", alucontrol_o, RESET_CTRL);
        check("rst_fin", aluflagin_o, 1'b0);
        check("rst_valid", valid_o, 1'b0);
        check("rst_result", result_o, 8'h00);
        check("rst_flag", flag_o, 1'b0);
        check("rst_rv", result_valid_o, 1'b0);
        check("rst_state", state_o, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Full load FA / 0F / 13
        press(8'hFA, 1, lat);
        check("lat_a", lat, 1 + LAT);
        check("state_b", state_o, 2'd1);
        press(8'h0F, 1, lat);
        check("lat_b", lat, 1 + LAT);
        sb_q.push_back(alu_ref(8'hFA, 8'h0F, 4'h3));
        press(8'h13, 1, lat);
        check("lat_op", lat, 1 + LAT);
        check("alua_fa", alua_o, 8'hFA);
        check("alub_0f", alub_o, 8'h0F);
        check("ctrl_3", alucontrol_o, 4'h3);
        check("fin_1", aluflagin_o, 1'b1);
        check("valid_1", valid_o, 1'b1);
        check("result_09", result_o, 8'h09);
        check("rv_1", result_valid_o, 1'b1);

        // Restart from READY; hold the button for 20 cycles
        press(8'h21, 20, lat);
        check("held_lat", lat, 1 + LAT);
        check("held_state", state_o, 2'd1);
        check("held_alua", alua_o, 8'h21);
        check("restart_rv", result_valid_o, 1'b0);
        check("restart_keep", result_o, 8'h09);
        press(8'h34, 1, lat);
        sb_q.push_back(alu_ref(8'h21, 8'h34, 4'h0));
        press(8'h00, 1, lat);
        check("fin_0", aluflagin_o, 1'b0);

        press(8'h55, 1, lat);
        check("r55_alua", alua_o, 8'h55);
        check("r55_state", state_o, 2'd1);
        check("r55_valid", valid_o, 1'b0);
        check("r55_rv", result_valid_o, 1'b0);
        check("r55_keep", result_o, 8'h20);
        press(8'h55, 1, lat);
        sb_q.push_back(alu_ref(8'h55, 8'h55, 4'h2));
        press(8'h12, 1, lat);
        check("ctrl_2", alucontrol_o, 4'h2);

        // Reset in LOAD_OP coinciding with a press, button held past release
        press(8'h77, 1, lat);
        press(8'h88, 1, lat);
        check("pre_rst_state", state_o, 2'd2);
        @(negedge clk);
        data_i = 8'h13;
        load_i = 1'b1;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_state", state_o, 2'd0);
        check("mrst_alua", alua_o, 8'h00);
        check("mrst_alub", alub_o, 8'h00);
        check("mrst_ctrl", alucontrol_o, RESET_CTRL);
        check("mrst_result", result_o, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("held_thru_rst", state_o, 2'd0);
        check("held_thru_alua", alua_o, 8'h00);
        @(negedge clk);
        load_i = 1'b0;
        repeat (4) @(negedge clk);

        // Final set after reset: add with carry out
        press(8'h80, 1, lat);
        check("post_rst_lat", lat, 1 + LAT);
        press(8'h80, 1, lat);
        sb_q.push_back(alu_ref(8'h80, 8'h80, 4'h3));
        press(8'h03, 1, lat);
        repeat (4) @(posedge clk);
        #2;
        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/module_alu_input_sequencer.md
# module_alu_input_sequencer

Upstream front end for `module_alu`. Loads operand A, operand B and the opcode/flag-in from one shared 8-bit switch bus, one value per press of a load button. Holds all ALU inputs in registers. Captures the ALU's combinational result into a result register once a full operand set is present.

## Interface

**Parameters**
- `RESET_CTRL`, default `4'h0`: value of `alucontrol_o` after reset.

**Ports**
- `clk_i` in, 1: single system clock. All state updates on the rising edge.
- `rst_i` in, 1: reset, synchronous, active-high.
- `data_i` in, `pkg_bits::bits_t` (8): switch bus. Holds A, B or opcode depending on state.
- `load_i` in, 1: load button, debounced level. Each rising edge is one load event.
- `aluresult_i` in, `bits_t`: `ALUResult_o` from the ALU.
- `aluflags_i` in, 1: `ALUFlags_o` from the ALU.
- `alua_o` out, `bits_t`: drives `ALUA_i`.
- `alub_o` out, `bits_t`: drives `ALUB_i`.
- `alucontrol_o` out, 4: drives `ALUControl_i`.
- `aluflagin_o` out, 1: drives `ALUFlagIn_i`.
- `valid_o` out, 1: A, B and opcode are all loaded.
- `result_o` out, `bits_t`: captured ALU result.
- `flag_o` out, 1: captured ALU flag.
- `result_valid_o` out, 1: `result_o` and `flag_o` hold the result for the current operand set.
- `state_o` out, 2: current FSM state, for the LEDs.

## Operation

**Load event**
- `ev = load_s & ~load_q`, where `load_s` is the (optionally synchronized) `load_i` and `load_q` is `load_s` registered.
- Holding the button produces exactly one event.

**FSM (`seq_state_t`)**
- `S_LOAD_A` (2'd0), on `ev`: `alua_o <= data_i`; go to `S_LOAD_B`.
- `S_LOAD_B` (2'd1), on `ev`: `alub_o <= data_i`; go to `S_LOAD_OP`.
- `S_LOAD_OP` (2'd2), on `ev`: `alucontrol_o <= data_i[3:0]`, `aluflagin_o <= data_i[4]` (`data_i[7:5]` ignored); go to `S_READY`.
- `S_READY` (2'd3), on `ev`: `alua_o <= data_i`; go to `S_LOAD_B`. Starts a new set with no wasted press.
- No `ev` in any state: hold all registers.

**Outputs**
- `valid_o` is 1 exactly while in `S_READY`.
- `result_valid_o` sets on the first cycle in `S_READY`, together with the result capture, and clears on the `ev` that leaves `S_READY`.
- Result capture: on the cycle where `state == S_READY && !result_valid_o`, latch `result_o <= aluresult_i` and `flag_o <= aluflags_i`.
- `result_o` and `flag_o` hold their value between captures, including while a new set is being loaded.
- Operand registers keep their previous values until overwritten. The ALU sees a mixed old/new set while `valid_o` is 0; downstream logic must qualify on `valid_o`.

**Reset**
- `rst_i` high at an edge, in any state (including mid-sequence): state goes to `S_LOAD_A`.
- Cleared to 0: `alua_o`, `alub_o`, `aluflagin_o`, `valid_o`, `result_o`, `flag_o`, `result_valid_o`, `state_o`, and the `load_q`/sync flops.
- `alucontrol_o` resets to `RESET_CTRL`.
- Reset has priority over `ev` in the same cycle.
- If `load_i` is still high when reset releases, no event fires until it has been low and rises again (`load_q` resets to 0 but re-samples high on the first cycle after reset).

## Timing

- All outputs are registered; there are no combinational paths from input to output.
- Without sync: `load_i` first sampled high at edge k, with `load_q` = 0, means `ev` during the cycle before k. The capture lands at edge k; new values are visible after edge k.
- With sync: the capture lands at edge k+2.
- Opcode captured at edge n: `valid_o` = 1 after n; the ALU settles within that cycle; result captured at n+1, so `result_valid_o` = 1 after n+1.
- Maximum rate: one event every 2 cycles (the input must be low for at least one sample between events).

## Configuration

- `ALU_SEQ_SYNC_EN` defined: a two-flop synchronizer sits in front of the edge detector, adding 2 cycles of latency. Required when `load_i` comes straight from a pad.
- `ALU_SEQ_SYNC_EN` undefined: `load_i` is taken as already synchronous to `clk_i` and `load_s = load_i`.

## Structure

- `pkg_bits` holds `bits_t` (8-bit logic), a new `seq_state_t` enum (`S_LOAD_A`, `S_LOAD_B`, `S_LOAD_OP`, `S_READY`, 2-bit encoding) and `OPC_W = 4`.
- One sub-module, `module_edge_detect`:
  - ports `clk_i`, `rst_i`, `sig_i`, `rise_o`;
  - owns the optional synchronizer and `load_q`.
- FSM and data registers live in the top module.

## Test plan

1. Reset check: hold `rst_i` for 2 cycles → all outputs 0, `alucontrol_o` = `RESET_CTRL`, `state_o` = 0.
2. Full load: `data_i` = 8'hFA + press, then 8'h0F + press, then 8'h13 + press → `alua_o` = FA, `alub_o` = 0F, `alucontrol_o` = 3, `aluflagin_o` = 1, `valid_o` = 1. With the ALU model returning 8'h09, `result_o` = 09 and `result_valid_o` = 1 one cycle after `valid_o` rises.
3. Held button: `load_i` high for 20 cycles in `S_LOAD_A` → exactly one capture; `state_o` = 1, not 2.
4. Restart from `S_READY`: press with `data_i` = 8'h55 → `alua_o` = 55, `state_o` = 1, `valid_o` = 0, `result_valid_o` = 0, `result_o` still holds its previous value.
5. Mid-sequence reset: assert `rst_i` in `S_LOAD_OP` on the same cycle as a press → state 0, operands 0, no capture of `data_i`.
6. With `ALU_SEQ_SYNC_EN`: measure press-to-capture → 2 cycles longer than in the build without it.
